// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared constants and FSM state encoding for the CPU data
//                memory bridge and its store buffer.
//  Contents    : ADDR_WIDTH, DATA_WIDTH, SB_DEPTH, state_t
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int SB_DEPTH   = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        RD_DONE = 3'd3,
        WR_REQ  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_bridge_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : Small circular FIFO of posted stores (word address, byte
//                strobes, data) with a word-address hit output used to hold
//                back loads that would bypass a buffered store.
//  Ports       : push/push_*   - enqueue one entry at the clock edge
//                pop           - dequeue the head entry at the clock edge
//                match_waddr   - word address compared against valid entries
//                match         - some valid entry holds match_waddr
//                count / full  - occupancy, 0..Depth
//                head_*        - contents of the oldest entry
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
    import dmem_pkg::*;
#(
    parameter int AddrWidth = ADDR_WIDTH,
    parameter int DataWidth = DATA_WIDTH,
    parameter int Depth     = SB_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [AddrWidth-3:0]           push_waddr,
    input  logic [DataWidth/8-1:0]         push_wstrb,
    input  logic [DataWidth-1:0]           push_wdata,
    input  logic                           pop,
    input  logic [AddrWidth-3:0]           match_waddr,
    output logic                           match,
    output logic                           full,
    output logic [$clog2(Depth+1)-1:0]     count,
    output logic [AddrWidth-3:0]           head_waddr,
    output logic [DataWidth/8-1:0]         head_wstrb,
    output logic [DataWidth-1:0]           head_wdata
);

    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntWidth = $clog2(Depth + 1);

    logic [PtrWidth-1:0]    head;
    logic [PtrWidth-1:0]    tail;
    logic [Depth-1:0]       valid;
    logic [Depth-1:0]       push_mask;
    logic [Depth-1:0]       pop_mask;
    logic [Depth-1:0]       hit;

    logic [AddrWidth-3:0]   waddr_mem [Depth];
    logic [DataWidth/8-1:0] wstrb_mem [Depth];
    logic [DataWidth-1:0]   wdata_mem [Depth];

    // Explicit wrap so the pointer stays in range even for a depth of one.
    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        if (p == PtrWidth'(Depth - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign push_mask = push ? (Depth'(1) << tail) : '0;
    assign pop_mask  = pop  ? (Depth'(1) << head) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (push) begin
                tail <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            // Push is never allowed when full, so the two masks never collide.
            valid <= (valid & ~pop_mask) | push_mask;
        end
    end

    // Payload storage needs no reset: the valid bits qualify every entry.
    always_ff @(posedge clk) begin
        if (push) begin
            waddr_mem[tail] <= push_waddr;
            wstrb_mem[tail] <= push_wstrb;
            wdata_mem[tail] <= push_wdata;
        end
    end

    for (genvar i = 0; i < Depth; i++) begin : g_match
        assign hit[i] = valid[i] && (waddr_mem[i] == match_waddr);
    end

    assign match      = |hit;
    assign full       = (count == CntWidth'(Depth));
    assign head_waddr = waddr_mem[head];
    assign head_wstrb = wstrb_mem[head];
    assign head_wdata = wdata_mem[head];

endmodule
`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_bridge
//  Description : CPU data-port to memory-port bridge. Stores are posted into
//                a small store buffer and complete without stalling; loads
//                stall the CPU, bypass the drain unless they hit a buffered
//                word, and return data in the RD_DONE cycle.
//  Ports       : clk, rst                - clock, async active-high reset
//                cpu_addr/read/wstrb/wdata - CPU access (held while stalled)
//                cpu_rdata, cpu_stall    - load data, stall to CPU
//                mem_req/we/addr/wstrb/wdata - memory request (held to grant)
//                mem_gnt, mem_rvalid, mem_rdata - memory responses
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int AddrWidth = ADDR_WIDTH,
    parameter int DataWidth = DATA_WIDTH,
    parameter int SbDepth   = SB_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AddrWidth-1:0]    cpu_addr,
    input  logic                    cpu_read,
    input  logic [DataWidth/8-1:0]  cpu_wstrb,
    input  logic [DataWidth-1:0]    cpu_wdata,
    output logic [DataWidth-1:0]    cpu_rdata,
    output logic                    cpu_stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [AddrWidth-1:0]    mem_addr,
    output logic [DataWidth/8-1:0]  mem_wstrb,
    output logic [DataWidth-1:0]    mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DataWidth-1:0]    mem_rdata
);

    localparam int CntWidth = $clog2(SbDepth + 1);

    state_t                 state;
    logic                   is_store;
    logic                   is_load;
    logic                   store_accept;
    logic                   drain_pop;
    logic                   sb_match;
    logic                   sb_full;
    logic [CntWidth-1:0]    sb_count;
    logic [AddrWidth-3:0]   head_waddr;
    logic [DataWidth/8-1:0] head_wstrb;
    logic [DataWidth-1:0]   head_wdata;
    logic                   unused_addr_lsbs;

    // Byte offset is irrelevant: all matching and memory traffic is per word.
    assign unused_addr_lsbs = ^cpu_addr[1:0];

    // A nonzero strobe makes the access a store even if cpu_read is also set.
    assign is_store     = |cpu_wstrb;
    assign is_load      = cpu_read && !is_store;
    assign store_accept = is_store && !sb_full;
    assign drain_pop    = (state == WR_REQ) && mem_gnt;

    // Fullness is judged before the same-cycle dequeue, so a store that meets
    // a drain grant still stalls one more cycle.
    assign cpu_stall = !rst && ((is_store && sb_full) ||
                                (is_load && (state != RD_DONE)));

    store_buffer #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth),
        .Depth     (SbDepth)
    ) u_store_buffer (
        .clk         (clk),
        .rst         (rst),
        .push        (store_accept),
        .push_waddr  (cpu_addr[AddrWidth-1:2]),
        .push_wstrb  (cpu_wstrb),
        .push_wdata  (cpu_wdata),
        .pop         (drain_pop),
        .match_waddr (cpu_addr[AddrWidth-1:2]),
        .match       (sb_match),
        .full        (sb_full),
        .count       (sb_count),
        .head_waddr  (head_waddr),
        .head_wstrb  (head_wstrb),
        .head_wdata  (head_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Loads win over draining unless they hit a buffered word,
                    // in which case the drain runs until the hit clears.
                    if (is_load && !sb_match) begin
                        state     <= RD_REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= {cpu_addr[AddrWidth-1:2], 2'b00};
                        mem_wstrb <= '0;
                        mem_wdata <= '0;
                    end else if (sb_count != '0) begin
                        state     <= WR_REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {head_waddr, 2'b00};
                        mem_wstrb <= head_wstrb;
                        mem_wdata <= head_wdata;
                    end
                end
                RD_REQ: begin
                    if (mem_gnt) begin
                        state   <= RD_WAIT;
                        mem_req <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        state     <= RD_DONE;
                        cpu_rdata <= mem_rdata;
                    end
                end
                RD_DONE: begin
                    state     <= IDLE;
                    cpu_rdata <= '0;
                end
                WR_REQ: begin
                    if (mem_gnt) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_bridge
//  Description : Self-checking bench for dmem_bridge. A transaction-level
//                model (queue of posted stores, outstanding-read flag, log of
//                memory handshakes) is checked every cycle; directed
//                scenarios add literal expectations on latency and ordering.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_bridge;

    localparam int DEPTH = 2;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic        cpu_read;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    // Memory responder knobs.
    bit          rv_auto;
    logic [31:0] rv_data;
    bit          rv_fire;
    bit          rv_force;
    logic [31:0] rv_force_data;

    // Model state.
    txn_t        sbq[$];
    txn_t        log_q[$];
    bit          rd_out;
    bit          res_valid;
    logic [31:0] res_data;
    txn_t        prev;
    bit          prev_req;
    bit          prev_gnt;

    always #5 clk = ~clk;

    dmem_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_read   (cpu_read),
        .cpu_wstrb  (cpu_wstrb),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic chk_log(input string name, input int idx, input logic we,
                           input logic [31:0] addr, input logic [31:0] data);
        if (idx >= log_q.size()) begin
            fail_now({name, "_missing"});
        end else begin
            chk({name, "_we"}, 32'(log_q[idx].we), 32'(we));
            chk({name, "_addr"}, log_q[idx].addr, addr);
            if (we) chk({name, "_data"}, log_q[idx].data, data);
        end
    endtask

    // Responder: read data one cycle after a read grant, or forced strays.
    always @(posedge clk) begin
        #2;
        mem_rvalid = rv_fire | rv_force;
        mem_rdata  = rv_fire ? rv_data : (rv_force ? rv_force_data : 32'h0);
    end

    // Per-cycle compare against the transaction model.
    bit          m_ld, m_st, m_full, m_exp_stall, m_rd_grant, m_wr_grant, m_got_rv;
    int          m_hits;
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_stall", 32'(cpu_stall), 32'd0);
            chk("rst_req", 32'(mem_req), 32'd0);
            chk("rst_rdata", cpu_rdata, 32'd0);
            sbq.delete();
            rd_out    = 0;
            res_valid = 0;
            prev_req  = 0;
            prev_gnt  = 0;
            rv_fire   = 0;
        end else begin
            m_st   = (cpu_wstrb != 4'b0);
            m_ld   = cpu_read && !m_st;
            m_full = (sbq.size() == DEPTH);
            m_exp_stall = m_st ? m_full : (m_ld ? !res_valid : 1'b0);
            chk("stall", 32'(cpu_stall), 32'(m_exp_stall));
            chk("rdata", cpu_rdata, res_valid ? res_data : 32'h0);
            if (rd_out || res_valid) chk("req_during_read", 32'(mem_req), 32'd0);
            if (prev_req && !prev_gnt) begin
                chk("hold_req", 32'(mem_req), 32'd1);
                chk("hold_we", 32'(mem_we), 32'(prev.we));
                chk("hold_addr", mem_addr, prev.addr);
                chk("hold_strb", 32'(mem_wstrb), 32'(prev.strb));
                chk("hold_data", mem_wdata, prev.data);
            end
            if (mem_req) chk("addr_align", 32'(mem_addr[1:0]), 32'd0);
            m_rd_grant = 0;
            m_wr_grant = 0;
            if (mem_req && mem_gnt) begin
                log_q.push_back('{we: mem_we, addr: mem_addr,
                                  strb: mem_we ? mem_wstrb : 4'h0,
                                  data: mem_we ? mem_wdata : 32'h0});
                if (mem_we) begin
                    if (sbq.size() == 0) begin
                        fail_now("write_without_store");
                    end else begin
                        chk("wr_addr", mem_addr, sbq[0].addr);
                        chk("wr_strb", 32'(mem_wstrb), 32'(sbq[0].strb));
                        chk("wr_data", mem_wdata, sbq[0].data);
                        m_wr_grant = 1;
                    end
                end else begin
                    chk("rd_is_load", 32'(m_ld), 32'd1);
                    chk("rd_addr", mem_addr, {cpu_addr[31:2], 2'b00});
                    m_hits = 0;
                    foreach (sbq[i]) if (sbq[i].addr == {cpu_addr[31:2], 2'b00}) m_hits++;
                    chk("rd_bypass_hazard", 32'(m_hits), 32'd0);
                    m_rd_grant = 1;
                end
            end
            m_got_rv = rd_out && mem_rvalid;
            if (m_st && !m_full)
                sbq.push_back('{we: 1'b1, addr: {cpu_addr[31:2], 2'b00},
                                strb: cpu_wstrb, data: cpu_wdata});
            if (m_wr_grant) void'(sbq.pop_front());
            res_valid = m_got_rv;
            res_data  = mem_rdata;
            if (m_got_rv) rd_out = 0;
            if (m_rd_grant) rd_out = 1;
            prev_req  = mem_req;
            prev_gnt  = mem_gnt;
            prev      = '{we: mem_we, addr: mem_addr, strb: mem_wstrb, data: mem_wdata};
            rv_fire   = rv_auto && m_rd_grant;
        end
    end

    task automatic idle(input int n);
        @(posedge clk); #1;
        cpu_read  = 0;
        cpu_wstrb = 0;
        cpu_addr  = 0;
        cpu_wdata = 0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic rd, output int stalls);
        bit done = 0;
        @(posedge clk); #1;
        cpu_addr = a; cpu_wdata = d; cpu_wstrb = s; cpu_read = rd;
        stalls = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (cpu_stall) begin
                stalls++;
                @(posedge clk); #1;
            end else begin
                done = 1;
            end
        end
        if (!done) fail_now("store_timeout");
    endtask

    task automatic do_load(input logic [31:0] a, output int stalls, output logic [31:0] data);
        bit done = 0;
        @(posedge clk); #1;
        cpu_addr = a; cpu_wdata = 0; cpu_wstrb = 0; cpu_read = 1;
        stalls = 0;
        data = 32'hx;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (cpu_stall) begin
                stalls++;
                @(posedge clk); #1;
            end else begin
                data = cpu_rdata;
                done = 1;
            end
        end
        if (!done) fail_now("load_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int st0, st1, st2, ld_st, l0, n_before;
        logic [31:0] rd;

        rst = 1; cpu_addr = 32'h200; cpu_read = 1; cpu_wstrb = 0; cpu_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        rv_auto = 0; rv_data = 0; rv_force = 0; rv_force_data = 0;
        repeat (2) @(negedge clk);
        chk("reset_stall_with_load", 32'(cpu_stall), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        rst = 0; cpu_read = 0; cpu_addr = 0;

        // 1: single store, grant always high.
        mem_gnt = 1;
        l0 = log_q.size();
        do_store(32'h100, 32'hDEADBEEF, 4'hF, 1'b0, st0);
        chk("s1_issue_stalls", 32'(st0), 32'd0);
        idle(6);
        chk("s1_log_count", 32'(log_q.size() - l0), 32'd1);
        chk_log("s1_write", l0, 1'b1, 32'h100, 32'hDEADBEEF);

        // 2: three stores with grant low; the third waits for the first grant.
        mem_gnt = 0;
        l0 = log_q.size();
        do_store(32'h10, 32'hAAAA0010, 4'hF, 1'b0, st0);
        do_store(32'h14, 32'hBBBB0014, 4'hF, 1'b0, st1);
        fork
            do_store(32'h18, 32'hCCCC0018, 4'hF, 1'b0, st2);
            begin
                repeat (3) @(posedge clk);
                #1 mem_gnt = 1;
            end
        join
        chk("s2_st0_stalls", 32'(st0), 32'd0);
        chk("s2_st1_stalls", 32'(st1), 32'd0);
        chk("s2_st2_stalls", 32'(st2), 32'd3);
        idle(10);
        chk("s2_log_count", 32'(log_q.size() - l0), 32'd3);
        chk_log("s2_w0", l0, 1'b1, 32'h10, 32'hAAAA0010);
        chk_log("s2_w1", l0 + 1, 1'b1, 32'h14, 32'hBBBB0014);
        chk_log("s2_w2", l0 + 2, 1'b1, 32'h18, 32'hCCCC0018);

        // 3: minimum-latency load.
        rv_auto = 1; rv_data = 32'h12345678;
        l0 = log_q.size();
        do_load(32'h200, ld_st, rd);
        chk("s3_stalls", 32'(ld_st), 32'd3);
        chk("s3_rdata", rd, 32'h12345678);
        idle(3);
        chk_log("s3_read", l0, 1'b0, 32'h200, 32'h0);

        // 4: load hitting a buffered word waits for the drain.
        rv_data = 32'h0BADF00D;
        l0 = log_q.size();
        do_store(32'h300, 32'hCAFEF00D, 4'hF, 1'b0, st0);
        do_load(32'h302, ld_st, rd);
        chk("s4_stalls", 32'(ld_st), 32'd5);
        chk("s4_rdata", rd, 32'h0BADF00D);
        idle(3);
        chk("s4_log_count", 32'(log_q.size() - l0), 32'd2);
        chk_log("s4_first_write", l0, 1'b1, 32'h300, 32'hCAFEF00D);
        chk_log("s4_then_read", l0 + 1, 1'b0, 32'h300, 32'h0);

        // 5: reset in RD_WAIT with a store still buffered, then stray rvalid.
        mem_gnt = 0; rv_auto = 0;
        do_store(32'h700, 32'h77777777, 4'hF, 1'b0, st0);
        @(posedge clk); #1;
        cpu_wstrb = 0; cpu_read = 1; cpu_addr = 32'h600;
        @(posedge clk); #1; mem_gnt = 1;
        @(posedge clk); #1; mem_gnt = 0;
        @(negedge clk);
        chk("s5_stall_in_wait", 32'(cpu_stall), 32'd1);
        @(posedge clk); #2;
        rst = 1; #1;
        chk("s5_rst_req", 32'(mem_req), 32'd0);
        chk("s5_rst_stall", 32'(cpu_stall), 32'd0);
        chk("s5_rst_rdata", cpu_rdata, 32'h0);
        n_before = log_q.size();
        @(posedge clk); #1;
        cpu_read = 0; cpu_addr = 0; mem_gnt = 1;
        @(posedge clk); #1;
        rst = 0; rv_force = 1; rv_force_data = 32'hBAD0BAD0;
        @(negedge clk);
        chk("s5_stray_rdata", cpu_rdata, 32'h0);
        @(posedge clk); #1; rv_force = 0;
        repeat (5) @(posedge clk);
        chk("s5_no_drain_after_rst", 32'(log_q.size() - n_before), 32'd0);
        chk("s5_idle_req", 32'(mem_req), 32'd0);

        // 6: non-hitting load bypasses a buffered store.
        mem_gnt = 0; rv_auto = 1; rv_data = 32'hA5A50400;
        l0 = log_q.size();
        do_store(32'h500, 32'h00000055, 4'hF, 1'b0, st0);
        fork
            do_load(32'h400, ld_st, rd);
            begin
                repeat (2) @(posedge clk);
                #1 mem_gnt = 1;
            end
        join
        chk("s6_stalls", 32'(ld_st), 32'd3);
        chk("s6_rdata", rd, 32'hA5A50400);
        idle(6);
        chk("s6_log_count", 32'(log_q.size() - l0), 32'd2);
        chk_log("s6_read_first", l0, 1'b0, 32'h400, 32'h0);
        chk_log("s6_then_write", l0 + 1, 1'b1, 32'h500, 32'h00000055);

        // 7: read and strobes together are a store only.
        l0 = log_q.size();
        do_store(32'h800, 32'h00001234, 4'b0011, 1'b1, st0);
        chk("s7_stalls", 32'(st0), 32'd0);
        idle(6);
        chk("s7_log_count", 32'(log_q.size() - l0), 32'd1);
        chk_log("s7_write", l0, 1'b1, 32'h800, 32'h00001234);
        if (log_q.size() > l0) chk("s7_strb", 32'(log_q[l0].strb), 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
